// File: rtl/cp0_regfile.sv
// CP0 register file: Count/Compare/Status/Cause/EPC/EBase, mtc0 commit, exception/eret update, timer and interrupt flags.
// Writes land on the next clk edge, reads and vector/interrupt outputs are combinational, no backpressure. Optional BadVAddr via CP0_BADVADDR_EN.
module cp0_regfile #(
    parameter logic [31:0] EBASE_RESET  = 32'h8000_0000,
    parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        WE,
    input  logic [4:0]  WAddr,
    input  logic [31:0] WData,
    input  logic [4:0]  RAddr,
    output logic [31:0] RData,
    input  logic        ExcValid,
    input  logic [4:0]  ExcCode,
    input  logic [31:0] ExcPC,
    input  logic        InDelaySlot,
`ifdef CP0_BADVADDR_EN
    input  logic [31:0] BadAddr,
`endif
    input  logic        Eret,
    input  logic [5:0]  HwInt,
    output logic [31:0] EbaseOutput,
    output logic [31:0] EpcOutput,
    output logic [31:0] StatusOutput,
    output logic [31:0] CauseOutput,
    output logic [31:0] ExcVector,
    output logic        TimerInt,
    output logic        IntPending
);

    localparam logic [4:0]  REG_BADVADDR = 5'd8;
    localparam logic [4:0]  REG_COUNT    = 5'd9;
    localparam logic [4:0]  REG_COMPARE  = 5'd11;
    localparam logic [4:0]  REG_STATUS   = 5'd12;
    localparam logic [4:0]  REG_CAUSE    = 5'd13;
    localparam logic [4:0]  REG_EPC      = 5'd14;
    localparam logic [4:0]  REG_EBASE    = 5'd15;
    localparam logic [31:0] STATUS_WMASK = 32'h0040_FF03;

    logic [31:0] count_q, compare_q, status_q, epc_q;
    logic [17:0] ebase_q;
    logic        bd_q, timer_q;
    logic [4:0]  exc_code_q;
    logic [1:0]  ip_sw_q;
    logic [5:0]  hw_q;

    logic [31:0] count_d, compare_d, status_d, epc_d;
    logic [17:0] ebase_d;
    logic        bd_d, timer_d;
    logic [4:0]  exc_code_d;
    logic [1:0]  ip_sw_d;
    logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc, wr_ebase;

    assign wr_count   = WE && (WAddr == REG_COUNT);
    assign wr_compare = WE && (WAddr == REG_COMPARE);
    assign wr_status  = WE && (WAddr == REG_STATUS);
    assign wr_cause   = WE && (WAddr == REG_CAUSE);
    assign wr_epc     = WE && (WAddr == REG_EPC);
    assign wr_ebase   = WE && (WAddr == REG_EBASE);

    // mtc0 (older WB instruction) is applied first; exception/eret then override.
    always_comb begin
        count_d    = wr_count   ? WData : count_q + 32'd1;
        compare_d  = wr_compare ? WData : compare_q;
        status_d   = wr_status  ? ((status_q & ~STATUS_WMASK) | (WData & STATUS_WMASK)) : status_q;
        ip_sw_d    = wr_cause   ? WData[9:8] : ip_sw_q;
        epc_d      = wr_epc     ? WData : epc_q;
        ebase_d    = wr_ebase   ? WData[29:12] : ebase_q;
        bd_d       = bd_q;
        exc_code_d = exc_code_q;
        if (wr_compare)
            timer_d = 1'b0;
        else if (count_q == compare_q)
            timer_d = 1'b1;
        else
            timer_d = timer_q;

        if (ExcValid) begin
            if (!status_d[1]) begin
                epc_d = InDelaySlot ? (ExcPC - 32'd4) : ExcPC;
                bd_d  = InDelaySlot;
            end
            exc_code_d  = ExcCode;
            status_d[1] = 1'b1;
        end else if (Eret) begin
            status_d[1] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= '0;
            compare_q  <= '0;
            status_q   <= STATUS_RESET;
            epc_q      <= '0;
            ebase_q    <= EBASE_RESET[29:12];
            bd_q       <= 1'b0;
            timer_q    <= 1'b0;
            exc_code_q <= '0;
            ip_sw_q    <= '0;
            hw_q       <= '0;
        end else begin
            count_q    <= count_d;
            compare_q  <= compare_d;
            status_q   <= status_d;
            epc_q      <= epc_d;
            ebase_q    <= ebase_d;
            bd_q       <= bd_d;
            timer_q    <= timer_d;
            exc_code_q <= exc_code_d;
            ip_sw_q    <= ip_sw_d;
            hw_q       <= HwInt;
        end
    end

`ifdef CP0_BADVADDR_EN
    logic [31:0] badvaddr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            badvaddr_q <= '0;
        else if (ExcValid && ((ExcCode == 5'd4) || (ExcCode == 5'd5)))
            badvaddr_q <= BadAddr;
    end
`else
    logic [31:0] badvaddr_q;
    assign badvaddr_q = '0;
`endif

    assign StatusOutput = status_q;
    assign EpcOutput    = epc_q;
    assign EbaseOutput  = {2'b10, ebase_q, 12'h000};
    assign CauseOutput  = {bd_q, 15'h0000, hw_q[5] | timer_q, hw_q[4:0], ip_sw_q, 1'b0, exc_code_q, 2'b00};
    assign TimerInt     = CauseOutput[15];
    assign ExcVector    = status_q[22] ? 32'hBFC0_0380 : {EbaseOutput[31:12], 12'h180};
    assign IntPending   = status_q[0] & ~status_q[1] & (|(CauseOutput[15:8] & status_q[15:8]));

    always_comb begin
        RData = '0;
        case (RAddr)
            REG_BADVADDR: RData = badvaddr_q;
            REG_COUNT:    RData = count_q;
            REG_COMPARE:  RData = compare_q;
            REG_STATUS:   RData = status_q;
            REG_CAUSE:    RData = CauseOutput;
            REG_EPC:      RData = epc_q;
            REG_EBASE:    RData = EbaseOutput;
            default:      RData = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_regfile.sv
// Bench for cp0_regfile: directed scenarios with literal expectations, then random traffic against a register-level model.
module tb_cp0_regfile;

    logic        clk;
    logic        rst;
    logic        WE;
    logic [4:0]  WAddr;
    logic [31:0] WData;
    logic [4:0]  RAddr;
    logic [31:0] RData;
    logic        ExcValid;
    logic [4:0]  ExcCode;
    logic [31:0] ExcPC;
    logic        InDelaySlot;
    logic        Eret;
    logic [5:0]  HwInt;
    logic [31:0] EbaseOutput, EpcOutput, StatusOutput, CauseOutput, ExcVector;
    logic        TimerInt, IntPending;
`ifdef CP0_BADVADDR_EN
    logic [31:0] BadAddr;
`endif

    int tests = 0;
    int fails = 0;

    cp0_regfile dut (
        .clk(clk), .rst(rst), .WE(WE), .WAddr(WAddr), .WData(WData),
        .RAddr(RAddr), .RData(RData), .ExcValid(ExcValid), .ExcCode(ExcCode),
        .ExcPC(ExcPC), .InDelaySlot(InDelaySlot),
`ifdef CP0_BADVADDR_EN
        .BadAddr(BadAddr),
`endif
        .Eret(Eret), .HwInt(HwInt),
        .EbaseOutput(EbaseOutput), .EpcOutput(EpcOutput), .StatusOutput(StatusOutput),
        .CauseOutput(CauseOutput), .ExcVector(ExcVector), .TimerInt(TimerInt),
        .IntPending(IntPending)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural register values as the software sees them.
    logic [31:0] m_count, m_compare, m_status, m_cause, m_epc, m_ebase, m_badv;
    logic        m_timer;

    always @(posedge clk or posedge rst) begin
        logic [31:0] n_count, n_compare, n_status, n_cause, n_epc, n_ebase;
        logic        n_timer;
        if (rst) begin
            m_count = 0; m_compare = 0; m_status = 32'h0040_0000;
            m_cause = 0; m_epc = 0; m_ebase = 32'h8000_0000; m_badv = 0; m_timer = 0;
        end else begin
            n_count   = (WE && WAddr == 9)  ? WData : m_count + 32'd1;
            n_compare = (WE && WAddr == 11) ? WData : m_compare;
            n_timer   = (WE && WAddr == 11) ? 1'b0 : ((m_count == m_compare) ? 1'b1 : m_timer);
            n_status  = m_status;
            if (WE && WAddr == 12)
                n_status = (m_status & ~32'h0040_FF03) | (WData & 32'h0040_FF03);
            n_cause = m_cause;
            if (WE && WAddr == 13)
                n_cause = (m_cause & ~32'h0000_0300) | (WData & 32'h0000_0300);
            n_cause[14:10] = HwInt[4:0];
            n_cause[15]    = HwInt[5] | n_timer;
            n_epc   = (WE && WAddr == 14) ? WData : m_epc;
            n_ebase = (WE && WAddr == 15) ? {2'b10, WData[29:12], 12'h000} : m_ebase;
            if (ExcValid) begin
                if (n_status[1] == 1'b0) begin
                    n_epc       = InDelaySlot ? ExcPC - 32'd4 : ExcPC;
                    n_cause[31] = InDelaySlot;
                end
                n_cause[6:2] = ExcCode;
                n_status[1]  = 1'b1;
`ifdef CP0_BADVADDR_EN
                if (ExcCode == 5'd4 || ExcCode == 5'd5) m_badv = BadAddr;
`endif
            end else if (Eret) begin
                n_status[1] = 1'b0;
            end
            m_count = n_count; m_compare = n_compare; m_timer = n_timer; m_status = n_status;
            m_cause = n_cause; m_epc = n_epc; m_ebase = n_ebase;
        end
    end

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
`ifdef CP0_BADVADDR_EN
            5'd8:  return m_badv;
`endif
            5'd9:  return m_count;
            5'd11: return m_compare;
            5'd12: return m_status;
            5'd13: return m_cause;
            5'd14: return m_epc;
            5'd15: return m_ebase;
            default: return 32'h0;
        endcase
    endfunction

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("rdata",  RData,        m_read(RAddr));
            chk("status", StatusOutput, m_status);
            chk("cause",  CauseOutput,  m_cause);
            chk("epc",    EpcOutput,    m_epc);
            chk("ebase",  EbaseOutput,  m_ebase);
            chk("vector", ExcVector,    m_status[22] ? 32'hBFC0_0380 : {m_ebase[31:12], 12'h180});
            chk("timer",  {31'h0, TimerInt}, {31'h0, m_cause[15]});
            chk("intpend", {31'h0, IntPending},
                {31'h0, m_status[0] & ~m_status[1] & (|(m_cause[15:8] & m_status[15:8]))});
        end
    end

    task automatic idle();
        WE = 0; WAddr = 0; WData = 0; ExcValid = 0; ExcCode = 0; ExcPC = 0;
        InDelaySlot = 0; Eret = 0; HwInt = 0;
`ifdef CP0_BADVADDR_EN
        BadAddr = 0;
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        WE = 1; WAddr = a; WData = d;
        tick();
        WE = 0;
    endtask

    task automatic exc(input logic [31:0] pc, input logic ds, input logic [4:0] code);
        ExcValid = 1; ExcPC = pc; InDelaySlot = ds; ExcCode = code;
        tick();
        ExcValid = 0; InDelaySlot = 0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] v);
        RAddr = a;
        #1;
        v = RData;
    endtask

    logic [31:0] v;

    initial begin
        rst = 1; RAddr = 0;
        idle();
        repeat (2) @(posedge clk);
        #1 rst = 0;

        chk("rst_status", StatusOutput, 32'h0040_0000);
        chk("rst_ebase",  EbaseOutput,  32'h8000_0000);
        chk("rst_vector", ExcVector,    32'hBFC0_0380);
        chk("rst_cause",  CauseOutput,  32'h0);

        // Asynchronous reset in mid-cycle.
        mtc0(9, 32'h55);
        rd(9, v);
        chk("count_55", v, 32'h55);
        #2 rst = 1;
        rd(9, v);
        chk("arst_count",  v, 32'h0);
        chk("arst_status", StatusOutput, 32'h0040_0000);
        chk("arst_ebase",  EbaseOutput,  32'h8000_0000);
        chk("arst_vector", ExcVector,    32'hBFC0_0380);
        chk("arst_model",  m_count,      32'h0);
        @(posedge clk);
        #1 rst = 0;

        // Writable masks.
        mtc0(12, 32'hFFFF_FFFF);
        chk("status_mask", StatusOutput, 32'h0040_FF03);
        chk("model_status_mask", m_status, 32'h0040_FF03);
        mtc0(15, 32'hFFFF_FFFF);
        chk("ebase_mask", EbaseOutput, 32'hBFFF_F000);
        mtc0(12, 32'h0);
        chk("vector_ebase", ExcVector, 32'hBFFF_F180);

        // Timer interrupt.
        mtc0(12, 32'h0000_8001);
        mtc0(11, 32'd20);
        mtc0(9, 32'd10);
        repeat (10) tick();
        rd(9, v);
        chk("count_20", v, 32'd20);
        chk("timer_not_yet", {31'h0, TimerInt}, 32'h0);
        tick();
        chk("timer_set", {31'h0, TimerInt}, 32'h1);
        chk("intpend_set", {31'h0, IntPending}, 32'h1);
        mtc0(11, 32'd5);
        chk("timer_clr", {31'h0, TimerInt}, 32'h0);

        // Exceptions and eret.
        exc(32'h8000_0104, 1'b1, 5'd8);
        chk("exc_epc", EpcOutput, 32'h8000_0100);
        chk("exc_bd",  {31'h0, CauseOutput[31]}, 32'h1);
        chk("exc_code", {27'h0, CauseOutput[6:2]}, 32'd8);
        chk("exc_exl", {31'h0, StatusOutput[1]}, 32'h1);
        exc(32'h9000_0000, 1'b0, 5'd4);
        chk("nested_epc", EpcOutput, 32'h8000_0100);
        chk("nested_code", {27'h0, CauseOutput[6:2]}, 32'd4);
        Eret = 1; tick(); Eret = 0;
        chk("eret_exl", {31'h0, StatusOutput[1]}, 32'h0);

        // Same-cycle collisions.
        WE = 1; WAddr = 14; WData = 32'h1234;
        exc(32'h40, 1'b0, 5'd10);
        WE = 0;
        chk("mtc0_vs_exc_epc", EpcOutput, 32'h40);
        Eret = 1;
        exc(32'h44, 1'b0, 5'd10);
        Eret = 0;
        chk("exc_beats_eret", {31'h0, StatusOutput[1]}, 32'h1);
        Eret = 1; tick(); Eret = 0;

        // Count wrap and write-over-increment.
        mtc0(9, 32'hFFFF_FFFF);
        rd(9, v);
        chk("count_max", v, 32'hFFFF_FFFF);
        tick();
        rd(9, v);
        chk("count_wrap", v, 32'h0);
        mtc0(9, 32'd7);
        rd(9, v);
        chk("count_write", v, 32'd7);

        // Random traffic; the negedge process compares against the model.
        for (int i = 0; i < 3000; i++) begin
            WE    = ($urandom_range(0, 1) == 1);
            WAddr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(8, 15));
            WData = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            ExcValid    = ($urandom_range(0, 7) == 0);
            ExcCode     = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(4, 5)) : 5'($urandom);
            ExcPC       = $urandom;
            InDelaySlot = ($urandom_range(0, 1) == 1);
            Eret        = ($urandom_range(0, 7) == 0);
            HwInt       = 6'($urandom);
            RAddr       = 5'($urandom);
`ifdef CP0_BADVADDR_EN
            BadAddr     = $urandom;
`endif
            tick();
        end
        idle();
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
